// File: rtl/gray_cipher_stream_engine.sv
// gray_cipher_stream_engine
//   Two-stage pipelined Gray-code cipher on DATA_W-bit words with valid/ready
//   streams on both sides. Private key comes from an internal Galois LFSR that
//   steps once per accepted beat; a new seed can be requested with key_load and
//   is applied only once the pipeline has drained.
// Ports
//   clk, rst_n           clock, async active-low reset
//   mode                 0 = encrypt, 1 = decrypt (sampled with the beat)
//   public_key           public key (sampled with the beat)
//   key_load, key_seed   private-key reseed request / value (0 -> KEY_SEED)
//   in_valid/in_ready/in_data     input stream
//   out_valid/out_ready/out_data  output stream
//   out_key              private key that was used for the current output beat
//   busy                 some pipeline stage holds a beat

// Combinational per-beat transform.
module gray_cipher_xform #(
  parameter int DATA_W = 16
) (
  input  logic              mode,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] pkey,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] nd, enc, x, bin;

  always_comb begin
    nd  = ~din;
    enc = nd ^ (nd >> 1) ^ key ^ pkey;
    // Decrypt: strip key/pubkey, then gray->binary as a running XOR from the MSB.
    x   = din ^ key ^ pkey;
    bin = x;
    for (int i = DATA_W - 2; i >= 0; i--) bin[i] = bin[i+1] ^ x[i];
    dout = mode ? ~bin : enc;
  end
endmodule

module gray_cipher_stream_engine #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] KEY_SEED  = 16'hACE1,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DATA_W-1:0] public_key,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_key,
  output logic              busy
);
  // vld_pipe[1] = s1 valid, vld_pipe[2] = s2 (output) valid
  logic [2:1]        vld_pipe;
  logic              s1_mode;
  logic [DATA_W-1:0] s1_data, s1_pkey, s1_key;
  logic [DATA_W-1:0] xf_out;
  logic [DATA_W-1:0] prv_key, seed_q, lfsr_next;
  logic              key_pending;
  logic              s1_en, s2_en, in_fire;

  assign s2_en     = !vld_pipe[2] | out_ready;
  assign s1_en     = !vld_pipe[1] | s2_en;
  assign in_ready  = s1_en & !key_pending;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[2];
  assign busy      = |vld_pipe;
  assign lfsr_next = (prv_key >> 1) ^ (prv_key[0] ? LFSR_TAPS : '0);

  gray_cipher_xform #(.DATA_W(DATA_W)) u_xf (
    .mode (s1_mode),
    .din  (s1_data),
    .key  (s1_key),
    .pkey (s1_pkey),
    .dout (xf_out)
  );

  // Pipeline stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_mode  <= 1'b0;
      s1_data  <= '0;
      s1_pkey  <= '0;
      s1_key   <= '0;
      out_data <= '0;
      out_key  <= '0;
    end else begin
      if (s1_en) begin
        vld_pipe[1] <= in_fire;
        if (in_fire) begin
          s1_mode <= mode;
          s1_data <= in_data;
          s1_pkey <= public_key;
          s1_key  <= prv_key;
        end
      end
      // out_data/out_key only move when s2 may advance, so they hold under backpressure
      if (s2_en) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data <= xf_out;
          out_key  <= s1_key;
        end
      end
    end
  end

  // Key schedule: reseed once drained (in_ready is low while pending, so the
  // load never coincides with an accept); otherwise step on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prv_key     <= KEY_SEED;
      key_pending <= 1'b0;
      seed_q      <= '0;
    end else if (key_pending && !busy) begin
      prv_key     <= (seed_q == '0) ? KEY_SEED : seed_q;
      key_pending <= 1'b0;
    end else begin
      if (key_load && !key_pending) begin
        key_pending <= 1'b1;
        seed_q      <= key_seed;
      end
      if (in_fire) prv_key <= lfsr_next;
    end
  end
endmodule

// File: tb/tb_gray_cipher_stream_engine.sv
module tb_gray_cipher_stream_engine;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        mode = 0;
  logic [15:0] public_key = '0;
  logic        key_load = 0;
  logic [15:0] key_seed = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] out_data, out_key;
  logic        busy;

  gray_cipher_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .public_key(public_key),
    .key_load(key_load), .key_seed(key_seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_key(out_key), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] data; logic [15:0] key; } exp_t;
  exp_t        sb[$];
  logic [15:0] rec_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, last_cyc = 0, prev_cyc = 0;
  logic [15:0] mkey = 16'hACE1, mseed = '0, last_data = '0, last_key = '0;
  logic        mpend = 0;
  logic        hold_v = 0;
  logic [15:0] hold_d = '0, hold_k = '0;
  logic        rnd_rdy = 0;
  logic [15:0] pt[1000], pk[1000];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_enc(input logic [15:0] d, k, p);
    logic [15:0] n = ~d;
    return (n ^ {1'b0, n[15:1]}) ^ k ^ p;
  endfunction

  function automatic logic [15:0] m_dec(input logic [15:0] d, k, p);
    logic [15:0] x = d ^ k ^ p;
    logic [15:0] b = x;
    for (int s = 1; s < 16; s++) b = b ^ (x >> s);
    return ~b;
  endfunction

  function automatic logic [15:0] m_lfsr(input logic [15:0] k);
    return (k >> 1) ^ (k[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor/scoreboard: all handshakes are resolved at negedge, where the
  // inputs driven #1 after the previous posedge are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mkey = 16'hACE1; mpend = 0; hold_v = 0;
    end else begin
      int n0;
      exp_t e;
      n0 = sb.size();
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_key", out_key, hold_k);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data; hold_k = out_key;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_key", out_key, e.key);
          last_data = out_data; last_key = out_key;
          prev_cyc = last_cyc; last_cyc = cyc;
          rec_q.push_back(out_data);
        end
      end
      if (mpend) chk("ready_pend", in_ready, 0);
      if (in_valid && in_ready) begin
        e.data = mode ? m_dec(in_data, mkey, public_key) : m_enc(in_data, mkey, public_key);
        e.key  = mkey;
        sb.push_back(e);
        mkey = m_lfsr(mkey);
      end
      if (mpend && n0 == 0) begin
        mkey = (mseed == 0) ? 16'hACE1 : mseed; mpend = 0;
      end else if (key_load && !mpend) begin
        mpend = 1; mseed = key_seed;
      end
    end
  end

  task automatic rr();
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic m, input logic [15:0] p, input logic [15:0] d);
    int t = 0;
    logic ok = 0;
    mode = m; public_key = p; in_data = d; in_valid = 1;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin t++; @(posedge clk); #1; rr(); end
    end
    if (!ok) chk("send_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 0; rr();
  endtask

  task automatic drain();
    int t = 0;
    rnd_rdy = 0; out_ready = 1;
    while (sb.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] s);
    key_load = 1; key_seed = s;
    @(posedge clk); #1;
    key_load = 0;
  endtask

  initial begin
    int acc;
    logic [15:0] v;
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_key", out_key, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1. encrypt after reset, latency
    mode = 0; public_key = 0; in_data = 16'h0000; in_valid = 1;
    @(negedge clk); chk("t1_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); chk("t1_lat_s1", out_valid, 0); chk("t1_busy", busy, 1);
    @(negedge clk); chk("t1_lat_s2", out_valid, 1);
    @(posedge clk); #1;
    chk("t1_data", last_data, 16'h2CE1);
    chk("t1_key", last_key, 16'hACE1);

    // 2. decrypt with fresh key (seed 0 -> KEY_SEED)
    load(16'h0000);
    send(1, 16'h0000, 16'h2CE1); drain();
    chk("t2_data", last_data, 16'h0000);
    chk("t2_key", last_key, 16'hACE1);

    // 3. back-to-back encrypt
    load(16'h0000);
    send(0, 0, 16'h1111); send(0, 0, 16'h2222); drain();
    chk("t3_key2", last_key, 16'hE270);
    chk("t3_gap", last_cyc - prev_cyc, 1);

    // 4. backpressure with continuous input
    out_ready = 0; mode = 0; in_valid = 1; in_data = $urandom; acc = 0;
    repeat (5) begin
      @(negedge clk); if (in_ready) acc++;
      @(posedge clk); #1 in_data = $urandom;
    end
    in_valid = 0;
    chk("t4_accepts", acc, 2);
    chk("t4_ready_low", in_ready, 0);
    drain();

    // 5. key load while busy; second request while pending is ignored
    out_ready = 0;
    send(0, 16'h0F0F, 16'hBEEF);
    load(16'h1234);
    load(16'h5555);
    repeat (3) begin @(negedge clk); chk("t5_ready", in_ready, 0); chk("t5_busy", busy, 1); end
    @(posedge clk); #1 out_ready = 1;
    send(0, 0, 16'hCAFE); drain();
    chk("t5_key", last_key, 16'h1234);
    load(16'h0000);
    send(0, 0, 16'h0000); drain();
    chk("t5_key0", last_key, 16'hACE1);

    // 2b. round trip of 1000 random words under random backpressure
    load(16'h3C5A); rec_q.delete(); rnd_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      pt[i] = $urandom; pk[i] = $urandom; send(0, pk[i], pt[i]);
    end
    drain();
    chk("rt_count_enc", rec_q.size(), 1000);
    load(16'h3C5A); rnd_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      v = (i < rec_q.size()) ? rec_q[i] : 16'h0; send(1, pk[i], v);
    end
    drain();
    chk("rt_count_dec", rec_q.size(), 2000);
    for (int i = 0; i < 1000 && 1000 + i < rec_q.size(); i++) chk("rt_word", rec_q[1000 + i], pt[i]);

    // 6. reset while output valid
    out_ready = 0;
    send(0, 0, 16'h7777);
    @(negedge clk); @(negedge clk);
    chk("t6_pre_valid", out_valid, 1);
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_out_data", out_data, 0);
    @(negedge clk); @(posedge clk); #1 rst_n = 1; out_ready = 1;
    repeat (4) @(negedge clk);
    chk("t6_no_stale", out_valid, 0);
    @(posedge clk); #1;
    send(0, 0, 16'h0000); drain();
    chk("t6_key", last_key, 16'hACE1);
    chk("t6_data", last_data, 16'h2CE1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
